rr_decode_arbiter: RTL and testbench



---
 rtl/rr_decode_arbiter.sv | 105 ++++++++++
 tb/tb_rr_decode_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - 8-way round-robin arbiter with registered grant index, decoded one-hot grant and tenure limit
module rr_decode_arbiter #(
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8,
  localparam int N_REQ   = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             preempt_q, preempt_d;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;

  // Rotating priority scan: the first requester at or after ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_GRANT;
          gnt_idx_d  = winner;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (!req[gnt_idx_q]) begin
          state_d = ST_IDLE;
          ptr_d   = gnt_idx_q + IDX_W'(1);
        end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          state_d   = ST_IDLE;
          ptr_d     = gnt_idx_q + IDX_W'(1);
          preempt_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  function automatic logic [3:0] dec2to4(input logic [1:0] a, input logic en);
    dec2to4 = en ? (4'b0001 << a) : 4'b0000;
  endfunction

  // idx[2] steers the enable between the low and high 2-to-4 halves.
  logic lo_en, hi_en;
  assign lo_en     = (state_q == ST_GRANT) && !gnt_idx_q[2];
  assign hi_en     = (state_q == ST_GRANT) &&  gnt_idx_q[2];
  assign gnt       = {dec2to4(gnt_idx_q[1:0], hi_en), dec2to4(gnt_idx_q[1:0], lo_en)};
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == ST_GRANT);
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - self-checking bench for rr_decode_arbiter
module tb_rr_decode_arbiter;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner, tenure length so far, next priority position.
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_tenure;
  bit m_pre;

  rr_decode_arbiter #(.IDX_W(3), .MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    if (!rst_n) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_tenure = 0; m_pre = 0;
    end else if (!m_valid) begin
      m_pre = 0;
      for (int k = 0; k < 8; k++) begin
        if (req[(m_ptr + k) % 8]) begin
          m_valid  = 1;
          m_idx    = (m_ptr + k) % 8;
          m_tenure = 1;
          break;
        end
      end
    end else if (!req[m_idx]) begin
      m_valid = 0; m_pre = 0; m_ptr = (m_idx + 1) % 8;
    end else if (m_tenure == MAX_HOLD) begin
      m_valid = 0; m_pre = 1; m_ptr = (m_idx + 1) % 8;
    end else begin
      m_tenure++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || preempt !== 1'b0 || gnt_idx !== 3'd0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: gnt=%h valid=%b preempt=%b idx=%0d, expected 00/0/0/0",
                 c, gnt, gnt_valid, preempt, gnt_idx);
      end
    end
    rst_n = 1'b1;
    req   = 8'h00;
    tick();
  endtask

  task automatic test_single();
    req = 8'h10;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++;
      if (gnt !== 8'h10 || gnt_idx !== 3'd4 || gnt_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL single cyc%0d: gnt=%h idx=%0d valid=%b, expected 10/4/1", c, gnt, gnt_idx, gnt_valid);
      end
    end
    req = 8'h00;
    tick();
    n_checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd4) begin
      n_fail++;
      $display("FAIL single_release: gnt=%h valid=%b idx=%0d, expected 00/0/4", gnt, gnt_valid, gnt_idx);
    end
    // ptr should now be 5: with 4 and 5 both requesting, 5 wins.
    req = 8'h30;
    tick();
    n_checks++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
      n_fail++;
      $display("FAIL single_ptr: gnt=%h idx=%0d, expected 20/5", gnt, gnt_idx);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 8'hFF;
    tick();
    for (int g = 0; g < 9; g++) begin
      n_checks++;
      if (gnt !== (8'h01 << (g % 8)) || gnt_idx !== 3'(g % 8) || gnt_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant%0d: gnt=%h idx=%0d valid=%b, expected %h/%0d/1",
                 g, gnt, gnt_idx, gnt_valid, 8'h01 << (g % 8), g % 8);
      end
      tick();
      tick();
      req = 8'hFF & ~(8'h01 << (g % 8));
      tick();
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle%0d: gnt=%h valid=%b, expected 00/0", g, gnt, gnt_valid);
      end
      req = 8'hFF;
      tick();
    end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    req = 8'h40;
    tick();
    req = 8'h00;
    tick();
    req = 8'h81;
    tick();
    n_checks++;
    if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
      n_fail++;
      $display("FAIL wrap_7: gnt=%h idx=%0d, expected 80/7", gnt, gnt_idx);
    end
    req = 8'h01;
    tick();
    tick();
    n_checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_0: gnt=%h idx=%0d, expected 01/0", gnt, gnt_idx);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_preempt();
    int hi_cycles;
    req = 8'h04;
    tick();
    hi_cycles = 0;
    for (int c = 0; c < MAX_HOLD + 4 && gnt === 8'h04; c++) begin
      if (preempt !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL preempt_early: preempt=%b at grant cycle %0d, expected 0", preempt, c);
      end
      hi_cycles++;
      tick();
    end
    n_checks++;
    if (hi_cycles != MAX_HOLD) begin
      n_fail++;
      $display("FAIL preempt_tenure: gnt high %0d cycles, expected %0d", hi_cycles, MAX_HOLD);
    end
    n_checks++;
    if (gnt !== 8'h00 || preempt !== 1'b1) begin
      n_fail++;
      $display("FAIL preempt_pulse: gnt=%h preempt=%b, expected 00/1", gnt, preempt);
    end
    tick();
    n_checks++;
    if (gnt !== 8'h04 || preempt !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_regrant: gnt=%h preempt=%b, expected 04/0", gnt, preempt);
    end
    // Release on the final tenure cycle counts as a normal release.
    for (int c = 0; c < MAX_HOLD - 1; c++) tick();
    req = 8'h00;
    tick();
    n_checks++;
    if (gnt !== 8'h00 || preempt !== 1'b0) begin
      n_fail++;
      $display("FAIL release_at_max: gnt=%h preempt=%b, expected 00/0", gnt, preempt);
    end
  endtask

  task automatic test_reset_mid();
    req = 8'h08;
    tick();
    for (int c = 0; c < 5; c++) tick();
    n_checks++;
    if (gnt !== 8'h08) begin
      n_fail++;
      $display("FAIL midrst_pre: gnt=%h, expected 08", gnt);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: gnt=%h valid=%b preempt=%b, expected 00/0/0", gnt, gnt_valid, preempt);
    end
    rst_n = 1'b1;
    req   = 8'h09;
    tick();
    n_checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_ptr: gnt=%h idx=%0d, expected 01/0", gnt, gnt_idx);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp_gnt;
    int         bad;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 15))
        0:       req = 8'($urandom);
        1, 2, 3: req = req ^ (8'h01 << $urandom_range(0, 7));
        default: ;
      endcase
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
      exp_gnt = m_valid ? (8'h01 << m_idx) : 8'h00;
      n_checks++;
      if (gnt !== exp_gnt || gnt_valid !== m_valid || gnt_idx !== 3'(m_idx) || preempt !== m_pre) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cyc%0d: gnt=%h valid=%b idx=%0d pre=%b, expected %h/%b/%0d/%b",
                   c, gnt, gnt_valid, gnt_idx, preempt, exp_gnt, m_valid, m_idx, m_pre);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    m_valid = 0; m_idx = 0; m_ptr = 0; m_tenure = 0; m_pre = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_preempt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
